// File: rtl/ext_rx_pkg.sv
// ext_rx_pkg: shared types and AR length helper for the mchan external read engine.
package ext_rx_pkg;

   typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi_resp_e;
   typedef enum logic {IDLE, RUN} rx_fsm_e;

   // Beat layout at the default widths; the top re-declares it at its own widths
   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [3:0]  tid;
      logic        first;
   } rx_beat_t;

   function automatic logic [7:0] calc_ar_len(input logic [15:0] add_lsb, input logic [31:0] len,
                                              input logic [3:0] off);
      logic [31:0] sum;
      sum = 32'(add_lsb) + len;
      return 8'(sum >> off);
   endfunction

endpackage

// File: rtl/ext_rx_burst_if_if.sv
// ext_rx_burst_if_if: AXI4 AR + R channel bundle with master/slave views.
interface ext_rx_burst_if_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int USER_W = 6,
   parameter int ID_W   = 4
);
   logic              ar_valid;
   logic [ADDR_W-1:0] ar_addr;
   logic [2:0]        ar_prot;
   logic [3:0]        ar_region;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              ar_lock;
   logic [3:0]        ar_cache;
   logic [3:0]        ar_qos;
   logic [ID_W-1:0]   ar_id;
   logic [USER_W-1:0] ar_user;
   logic              ar_ready;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_last;
   logic [ID_W-1:0]   r_id;
   logic [USER_W-1:0] r_user;
   logic              r_ready;

   modport master (
      output ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_qos, ar_id, ar_user, r_ready,
      input  ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
   );

   modport slave (
      input  ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_qos, ar_id, ar_user, r_ready,
      output ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
   );

endinterface

// File: rtl/ext_rx_fifo.sv
// ext_rx_fifo: power-of-2 deep synchronous FIFO of R beats with full/empty flags.
module ext_rx_fifo
   import ext_rx_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = rx_beat_t
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd];

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wr  <= '0;
         rd  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end

   always_ff @(posedge clk_i)
      if (do_push) mem[wr] <= din;

endmodule

// File: rtl/ext_rx_burst_if.sv
// ext_rx_burst_if: AXI4 read engine (AR slot, R beat buffer, per-burst events).
// Optional EXT_RX_RESP_ERR_EN enables sticky SLVERR/DECERR reporting.
module ext_rx_burst_if
   import ext_rx_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int AXI_USER_WIDTH  = 6,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int EXT_ADD_WIDTH   = 29,
   parameter int EXT_TID_WIDTH   = 4,
   parameter int MCHAN_LEN_WIDTH = 15,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RX_FIFO_DEPTH   = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [EXT_ADD_WIDTH-1:0]           cmd_add_i,
   input  logic [MCHAN_LEN_WIDTH-1:0]         cmd_len_i,
   input  logic [EXT_TID_WIDTH-1:0]           cmd_tid_i,
   input  logic                               cmd_bst_i,
   input  logic                               cmd_req_i,
   output logic                               cmd_gnt_o,
   input  logic                               valid_tid_i,
   ext_rx_burst_if_if.master                  axi,
   output logic [AXI_DATA_WIDTH-1:0]          rx_data_dat_o,
   output logic                               rx_data_first_o,
   output logic                               rx_data_last_o,
   output logic                               rx_data_valid_o,
   input  logic                               rx_data_ready_i,
   output logic                               trans_rx_req_o,
   output logic                               release_tid_o,
   output logic [EXT_TID_WIDTH-1:0]           res_tid_o,
   output logic                               synch_req_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                               err_o,
   output logic [EXT_TID_WIDTH-1:0]           err_tid_o
);
   localparam int OFF = $clog2(AXI_DATA_WIDTH/8);
   localparam int OW  = $clog2(MAX_OUTSTANDING+1);

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic                      last;
      logic [EXT_TID_WIDTH-1:0]  tid;
      logic                      first;
   } beat_t;

   beat_t                     push_beat, head;
   rx_fsm_e                   state;
   logic                      full, empty, push, pop, pop_last, slot_q, bst_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                len_q;
   logic [EXT_TID_WIDTH-1:0]  tid_q;

   assign cmd_gnt_o = cmd_req_i & valid_tid_i & (~slot_q | axi.ar_ready) &
                      (outstanding_o < OW'(MAX_OUTSTANDING));

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         slot_q <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         bst_q  <= 1'b0;
         tid_q  <= '0;
      end else if (cmd_gnt_o) begin
         slot_q <= 1'b1;
         addr_q <= AXI_ADDR_WIDTH'(cmd_add_i);
         len_q  <= calc_ar_len(16'(cmd_add_i[OFF-1:0]), 32'(cmd_len_i), 4'(OFF));
         bst_q  <= cmd_bst_i;
         tid_q  <= cmd_tid_i;
      end else if (axi.ar_ready) slot_q <= 1'b0;

   assign axi.ar_valid  = slot_q;
   assign axi.ar_addr   = addr_q;
   assign axi.ar_len    = len_q;
   assign axi.ar_size   = 3'(OFF);
   assign axi.ar_burst  = {1'b0, bst_q};
   assign axi.ar_id     = AXI_ID_WIDTH'(tid_q);
   assign axi.ar_prot   = '0;
   assign axi.ar_region = '0;
   assign axi.ar_lock   = 1'b0;
   assign axi.ar_cache  = '0;
   assign axi.ar_qos    = '0;
   assign axi.ar_user   = '0;

   // A burst stays outstanding until its last beat leaves the buffer
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) outstanding_o <= '0;
      else if (cmd_gnt_o & ~pop_last) outstanding_o <= outstanding_o + 1'b1;
      else if (pop_last & ~cmd_gnt_o) outstanding_o <= outstanding_o - 1'b1;

   assign axi.r_ready = ~full;
   assign push        = axi.r_valid & ~full;
   assign push_beat   = {axi.r_data, axi.r_last, axi.r_id[EXT_TID_WIDTH-1:0], state == IDLE};

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else if (push) state <= axi.r_last ? IDLE : RUN;

   ext_rx_fifo #(.DEPTH(RX_FIFO_DEPTH), .T(beat_t)) i_fifo (
      .clk_i, .rst_ni, .push, .pop, .din(push_beat), .dout(head), .full, .empty
   );

   assign pop             = ~empty & rx_data_ready_i;
   assign pop_last        = pop & head.last;
   assign rx_data_valid_o = ~empty;
   assign rx_data_dat_o   = empty ? '0 : head.data;
   assign rx_data_first_o = ~empty & head.first;
   assign rx_data_last_o  = ~empty & head.last;
   assign res_tid_o       = empty ? '0 : head.tid;
   assign trans_rx_req_o  = pop & head.first;
   assign release_tid_o   = pop_last;
   assign synch_req_o     = pop_last;

`ifdef EXT_RX_RESP_ERR_EN
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         err_o     <= 1'b0;
         err_tid_o <= '0;
      end else if (push && (axi.r_resp == SLVERR || axi.r_resp == DECERR)) begin
         err_o <= 1'b1;
         if (!err_o) err_tid_o <= axi.r_id[EXT_TID_WIDTH-1:0];
      end
`else
   assign err_o     = 1'b0;
   assign err_tid_o = '0;
`endif

endmodule

// File: tb/tb_ext_rx_burst_if.sv
// tb_ext_rx_burst_if: scoreboard bench for ext_rx_burst_if (64-bit, 2 outstanding, depth 4).
module tb_ext_rx_burst_if;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [3:0]  tid;
      logic        first;
   } exp_t;

   logic        clk = 0, rst_n = 0;
   logic [28:0] cmd_add = '0;
   logic [14:0] cmd_len = '0;
   logic [3:0]  cmd_tid = '0;
   logic        cmd_bst = 0, cmd_req = 0, cmd_gnt, valid_tid = 1;
   logic [63:0] rx_dat;
   logic        rx_first, rx_last, rx_valid, rx_ready = 1;
   logic        trans_rx, release_tid, synch_req, err;
   logic [3:0]  res_tid, err_tid;
   logic [1:0]  outstanding;

   int   n_cmp = 0, n_err = 0, n_pop = 0;
   bit   in_burst = 0;
   exp_t sb[$];
   exp_t mon_e;

   ext_rx_burst_if_if #(.ADDR_W(32), .DATA_W(64), .USER_W(6), .ID_W(4)) axi ();

   ext_rx_burst_if #(.MAX_OUTSTANDING(2), .RX_FIFO_DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_add_i(cmd_add), .cmd_len_i(cmd_len), .cmd_tid_i(cmd_tid), .cmd_bst_i(cmd_bst),
      .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .valid_tid_i(valid_tid),
      .axi(axi),
      .rx_data_dat_o(rx_dat), .rx_data_first_o(rx_first), .rx_data_last_o(rx_last),
      .rx_data_valid_o(rx_valid), .rx_data_ready_i(rx_ready),
      .trans_rx_req_o(trans_rx), .release_tid_o(release_tid), .res_tid_o(res_tid),
      .synch_req_o(synch_req), .outstanding_o(outstanding), .err_o(err), .err_tid_o(err_tid)
   );

   always #5 clk = ~clk;

   // Scoreboard: every visible pop must match the oldest accepted beat
   always @(negedge clk)
      if (rst_n && rx_valid && rx_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: popped data %h with nothing expected", rx_dat);
         end else begin
            mon_e = sb.pop_front();
            n_pop++;
            if ({rx_dat, rx_first, rx_last, res_tid, trans_rx, release_tid, synch_req} !==
                {mon_e.data, mon_e.first, mon_e.last, mon_e.tid, mon_e.first, mon_e.last, mon_e.last}) begin
               n_err++;
               $display("FAIL pop_beat: got dat=%h f=%b l=%b tid=%h tr=%b rel=%b syn=%b, want dat=%h f=%b l=%b tid=%h tr=%b rel=%b syn=%b",
                        rx_dat, rx_first, rx_last, res_tid, trans_rx, release_tid, synch_req,
                        mon_e.data, mon_e.first, mon_e.last, mon_e.tid, mon_e.first, mon_e.last, mon_e.last);
            end
         end
      end

   task automatic issue_cmd(input logic [28:0] a, input logic [14:0] l, input logic [3:0] t, input logic b);
      int n = 0;
      @(posedge clk); #1;
      cmd_add = a; cmd_len = l; cmd_tid = t; cmd_bst = b; cmd_req = 1;
      do begin @(negedge clk); n++; end while (!cmd_gnt && n < 100);
      if (!cmd_gnt) begin
         n_cmp++; n_err++;
         $display("FAIL gnt_timeout: cmd_gnt=%b required 1 within 100 cycles", cmd_gnt);
      end
      @(posedge clk); #1;
      cmd_req = 0;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic l, input logic [3:0] id, input logic [1:0] resp);
      int   n = 0;
      exp_t e;
      @(posedge clk); #1;
      axi.r_valid = 1; axi.r_data = d; axi.r_last = l; axi.r_id = id; axi.r_resp = resp;
      do begin @(negedge clk); n++; end while (!axi.r_ready && n < 100);
      if (!axi.r_ready) begin
         n_cmp++; n_err++;
         $display("FAIL r_ready_timeout: r_ready=%b required 1 within 100 cycles", axi.r_ready);
      end else begin
         e.data = d; e.last = l; e.tid = id; e.first = !in_burst;
         in_burst = !l;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      axi.r_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d beats left, required 0", sb.size());
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({axi.ar_valid, cmd_gnt, rx_valid, outstanding, trans_rx, release_tid, synch_req, err, err_tid, res_tid, rx_dat} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: arv=%b gnt=%b rxv=%b out=%0d tr=%b rel=%b syn=%b err=%b etid=%h tid=%h dat=%h, required all 0",
                  axi.ar_valid, cmd_gnt, rx_valid, outstanding, trans_rx, release_tid, synch_req, err, err_tid, res_tid, rx_dat);
      end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_ar_hold();
      @(posedge clk); #1;
      axi.ar_ready = 0;
      cmd_add = 29'h1003; cmd_len = 15'd12; cmd_tid = 4'd3; cmd_bst = 1; cmd_req = 1;
      @(negedge clk);
      n_cmp++;
      if ({cmd_gnt, axi.ar_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL ar_gnt: gnt=%b ar_valid=%b, required gnt=1 ar_valid=0", cmd_gnt, axi.ar_valid);
      end
      @(posedge clk); #1;
      cmd_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id} !==
          {1'b1, 32'h1003, 8'd1, 3'd3, 2'b01, 4'd3}) begin
         n_err++;
         $display("FAIL ar_fields: v=%b addr=%h len=%0d size=%0d burst=%b id=%0d, required v=1 addr=1003 len=1 size=3 burst=01 id=3",
                  axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({axi.ar_valid, axi.ar_addr, axi.ar_len} !== {1'b1, 32'h1003, 8'd1}) begin
            n_err++;
            $display("FAIL ar_hold: cycle %0d v=%b addr=%h len=%0d, required held v=1 addr=1003 len=1",
                     i, axi.ar_valid, axi.ar_addr, axi.ar_len);
         end
      end
      @(posedge clk); #1;
      axi.ar_ready = 1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({axi.ar_valid, outstanding} !== {1'b0, 2'd1}) begin
         n_err++;
         $display("FAIL ar_handshake: ar_valid=%b out=%0d, required ar_valid=0 out=1", axi.ar_valid, outstanding);
      end
      send_beat(64'hA0A0_0000_0000_0001, 0, 4'd3, 2'b00);
      send_beat(64'hA0A0_0000_0000_0002, 1, 4'd3, 2'b00);
      drain();
      n_cmp++;
      if (outstanding !== 2'd0) begin
         n_err++;
         $display("FAIL ar_outstanding_done: out=%0d, required 0", outstanding);
      end
   endtask

   task automatic test_single_beat();
      issue_cmd(29'h40, 15'd7, 4'd9, 1);
      send_beat(64'hBEEF_0000_0000_0009, 1, 4'd9, 2'b00);
      drain();
   endtask

   task automatic test_outstanding();
      int n = 0, pops;
      issue_cmd(29'h0, 15'd7, 4'd1, 1);
      issue_cmd(29'h8, 15'd7, 4'd2, 1);
      @(posedge clk); #1;
      cmd_add = 29'h10; cmd_len = 15'd7; cmd_tid = 4'd3; cmd_bst = 1; cmd_req = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({cmd_gnt, outstanding} !== {1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL max_outstanding: gnt=%b out=%0d, required gnt=0 out=2", cmd_gnt, outstanding);
         end
      end
      pops = n_pop;
      send_beat(64'hC1, 1, 4'd1, 2'b00);
      while (!cmd_gnt && n < 100) begin @(negedge clk); n++; end
      n_cmp++;
      if ({cmd_gnt, outstanding} !== {1'b1, 2'd1} || n_pop != pops + 1) begin
         n_err++;
         $display("FAIL gnt_after_pop: gnt=%b out=%0d pops=%0d, required gnt=1 out=1 pops=%0d",
                  cmd_gnt, outstanding, n_pop - pops, 1);
      end
      @(posedge clk); #1;
      cmd_req = 0;
      send_beat(64'hC2, 1, 4'd2, 2'b00);
      send_beat(64'hC3, 1, 4'd3, 2'b00);
      drain();
      n_cmp++;
      if (outstanding !== 2'd0) begin
         n_err++;
         $display("FAIL outstanding_done: out=%0d, required 0", outstanding);
      end
   endtask

   task automatic test_backpressure();
      int pops;
      pops = n_pop;
      issue_cmd(29'h0, 15'd47, 4'd4, 1);
      rx_ready = 0;
      for (int i = 0; i < 4; i++) send_beat(64'hD000 + 64'(i), 0, 4'd4, 2'b00);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({axi.r_ready, rx_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL fifo_full: r_ready=%b rx_valid=%b, required r_ready=0 rx_valid=1", axi.r_ready, rx_valid);
         end
      end
      @(posedge clk); #1;
      rx_ready = 1;
      send_beat(64'hD004, 0, 4'd4, 2'b00);
      send_beat(64'hD005, 1, 4'd4, 2'b00);
      drain();
      n_cmp++;
      if (n_pop - pops != 6 || outstanding !== 2'd0) begin
         n_err++;
         $display("FAIL backpressure_count: pops=%0d out=%0d, required pops=6 out=0", n_pop - pops, outstanding);
      end
   endtask

   task automatic test_err();
      n_cmp++;
      if ({err, err_tid} !== 5'd0) begin
         n_err++;
         $display("FAIL err_initial: err=%b err_tid=%0d, required 0/0", err, err_tid);
      end
      issue_cmd(29'h0, 15'd7, 4'd5, 1);
      send_beat(64'hE5, 1, 4'd5, 2'b10);
      issue_cmd(29'h0, 15'd7, 4'd7, 1);
      send_beat(64'hE7, 1, 4'd7, 2'b11);
      drain();
      n_cmp++;
`ifdef EXT_RX_RESP_ERR_EN
      if ({err, err_tid} !== {1'b1, 4'd5}) begin
         n_err++;
         $display("FAIL err_capture: err=%b err_tid=%0d, required err=1 err_tid=5", err, err_tid);
      end
`else
      if ({err, err_tid} !== 5'd0) begin
         n_err++;
         $display("FAIL err_disabled: err=%b err_tid=%0d, required 0/0", err, err_tid);
      end
`endif
   endtask

   task automatic test_reset_mid();
      issue_cmd(29'h0, 15'd31, 4'd6, 1);
      rx_ready = 0;
      send_beat(64'hF0, 0, 4'd6, 2'b00);
      send_beat(64'hF1, 0, 4'd6, 2'b00);
      axi.ar_ready = 0;
      issue_cmd(29'h0, 15'd7, 4'd8, 1);
      @(negedge clk);
      n_cmp++;
      if ({axi.ar_valid, rx_valid, outstanding} !== {1'b1, 1'b1, 2'd2}) begin
         n_err++;
         $display("FAIL pre_reset: arv=%b rxv=%b out=%0d, required 1/1/2", axi.ar_valid, rx_valid, outstanding);
      end
      @(posedge clk); #1;
      rst_n = 0; rx_ready = 1;
      sb.delete(); in_burst = 0;
      @(negedge clk);
      n_cmp++;
      if ({axi.ar_valid, rx_valid, outstanding, release_tid, synch_req, err} !== '0) begin
         n_err++;
         $display("FAIL reset_mid: arv=%b rxv=%b out=%0d rel=%b syn=%b err=%b, required all 0",
                  axi.ar_valid, rx_valid, outstanding, release_tid, synch_req, err);
      end
      @(posedge clk); #1;
      rst_n = 1; axi.ar_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({rx_valid, release_tid, outstanding} !== '0) begin
            n_err++;
            $display("FAIL post_reset: rxv=%b rel=%b out=%0d, required all 0", rx_valid, release_tid, outstanding);
         end
      end
   endtask

   initial begin
      axi.ar_ready = 1;
      axi.r_valid = 0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 0; axi.r_id = '0; axi.r_user = '0;
      test_reset();
      test_ar_hold();
      test_single_beat();
      test_outstanding();
      test_backpressure();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
